// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
`default_nettype none

interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;

  modport master (output imem_req, output imem_addr, input  imem_ack);
  modport slave  (input  imem_req, input  imem_addr, output imem_ack);
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer - owns the fetch PC; sequences imem requests with redirect
//                   and stall handling for the IF stage.   Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fetch_sequencer_if.master imem,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic              kill1_o,
  output logic              misalign_err_o,
  output logic [CNT_W-1:0]  redirect_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pending_q, pending_d;
  logic              misalign_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_inc;
  logic [ADDR_W-1:0] tgt_aligned;

  assign tgt_aligned = {redirect_target_i[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      if (redirect_valid_i && (redirect_target_i[1:0] != 2'b00))
        misalign_q <= 1'b1;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    imem.imem_req = 1'b0;
    fetch_valid_o = 1'b0;
    kill1_o       = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid_i) begin
          pc_d    = tgt_aligned;
          cnt_inc = 1'b1;
        end
      end
      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          if (redirect_valid_i) begin
            kill1_o = 1'b1;
            pc_d    = tgt_aligned;
          end else begin
            fetch_valid_o = 1'b1;
            if (stall_i) state_d = HOLD;
            else         pc_d    = pc_q + C_PC_STEP;
          end
        end else if (redirect_valid_i) begin
          // Address must stay put until ack; park the target until then.
          kill1_o   = 1'b1;
          pending_d = tgt_aligned;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        imem.imem_req = 1'b1;
        if (redirect_valid_i) begin
          kill1_o   = 1'b1;
          pending_d = tgt_aligned;
        end
        if (imem.imem_ack) begin
          pc_d    = redirect_valid_i ? tgt_aligned : pending_q;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          kill1_o = 1'b1;
          pc_d    = tgt_aligned;
          state_d = REQ;
        end else begin
          fetch_valid_o = 1'b1;
          if (!stall_i) begin
            pc_d    = pc_q + C_PC_STEP;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (kill1_o) cnt_inc = 1'b1;
  end

  assign imem.imem_addr = pc_q;
  assign fetch_pc_o     = pc_q;
  assign misalign_err_o = misalign_q;
  assign redirect_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the fetch PC and sequences instruction-memory requests for the IF stage. It arbitrates between sequential fetch (PC+4), redirects from the branch/jump resolution logic, and stalls from the hazard unit. Its handshake with a variable-latency instruction memory ensures a redirect arriving mid-request never corrupts the address bus or leaks a wrong-path instruction into IF/ID. It sits between the PC-control logic and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, fetch address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 8, width of saturating redirect counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard-unit stall; IF/ID must not advance
redirect_valid  in  1  taken branch/jump/call/return this cycle
redirect_target  in  ADDR_W  redirect address (already computed upstream)
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address
imem_ack  in  1  memory returns the instruction for imem_addr this cycle
fetch_valid  out  1  instruction slot at IF/ID input is valid
fetch_pc  out  ADDR_W  PC of the slot presented to IF/ID
kill1  out  1  one-cycle squash of the IF/ID slot
misalign_err  out  1  sticky: redirect_target[1:0] was nonzero
redirect_cnt  out  CNT_W  saturating count of accepted redirects

Behaviour:
- reset low (any time, including mid-request): pc=RESET_PC, pending=0, state=IDLE, misalign_err=0, redirect_cnt=0; all 1-bit outputs 0. No handshake continues across reset.
- States: IDLE, REQ, DRAIN, HOLD. Register state, pc and pending; outputs decode from state and inputs.
- IDLE: imem_req=0. Next cycle -> REQ. redirect_valid in IDLE: pc<=target, still -> REQ, kill1=0 because nothing is in flight.
- Handshake rule: once imem_req=1, imem_req and imem_addr stay constant until the cycle imem_ack=1. imem_ack outside REQ/DRAIN is ignored.
- REQ: imem_req=1, imem_addr=pc, fetch_pc=pc.
  - ack & !redirect & !stall: fetch_valid=1 (same cycle as ack), pc<=pc+4, stay REQ. Back-to-back 1-cycle fetches give one instruction per cycle.
  - ack & stall & !redirect: fetch_valid=1, -> HOLD, pc unchanged.
  - ack & redirect: fetch_valid=0, kill1=1, pc<=target, stay REQ.
  - !ack & redirect: kill1=1, pending<=target, -> DRAIN.
  - !ack & !redirect: hold.
- DRAIN: imem_req=1, imem_addr=pc (old address, per handshake rule), fetch_valid=0.
  - redirect in DRAIN: pending<=new target (latest wins), kill1=1.
  - ack: pc<=pending (or the same-cycle redirect_target if redirect_valid), -> REQ. The returned instruction is discarded.
- HOLD: imem_req=0, fetch_valid=1, fetch_pc=pc.
  - !stall & !redirect: pc<=pc+4, -> REQ.
  - redirect (priority over stall): fetch_valid=0, kill1=1, pc<=target, -> REQ.
- Priority: reset > redirect > stall > sequential.
- Alignment: targets are loaded with bits [1:0] forced to 00. Nonzero target[1:0] on an accepted redirect sets misalign_err, which clears only on reset.
- pc+4 wraps modulo 2^ADDR_W (max-4 -> 0), with no error.
- redirect_cnt increments on every cycle with kill1=1 or an IDLE redirect, and saturates at all-ones.
- kill1 is never asserted in the same cycle as fetch_valid=1.

Test Plan:
- Reset release, imem_ack tied 1, no stall/redirect: imem_addr 0,4,8,C on consecutive cycles; fetch_valid=1 each cycle. Assert reset low mid-stream: imem_req=0 and pc=0 immediately, asynchronously.
- imem_ack delayed 3 cycles with redirect_target=0x40 in cycle 1: kill1 pulses once; imem_addr stays 0x0 until ack; no fetch_valid; next request is 0x40; redirect_cnt=1.
- Two redirects (0x40, then 0x80) during one outstanding request: kill1 pulses twice; next address is 0x80; redirect_cnt=2.
- Ack with stall high for 2 cycles: state HOLD, fetch_valid=1, fetch_pc=0x8, imem_req=0; after stall drops, imem_addr=0xC. Redirect to 0x100 during HOLD: kill1=1, fetch_valid=0, next address 0x100.
- Redirect coincident with ack, target=0x22: fetch_valid=0, next address 0x20, misalign_err=1, and it stays 1 until reset.
- RESET_PC=0xFFFF_FFF8 with ack tied 1: addresses FFFF_FFF8, FFFF_FFFC, 0, 4. Force 260 redirects: redirect_cnt saturates at 0xFF.
